// File: rtl/rand_delay_timer.sv
// rand_delay_timer
// Random-delay scheduler for the reaction-time game. While idle it lets the
// upstream LFSR free-run. On start it latches the LFSR value and converts it
// to MIN_MS + (rnd << SCALE_SHIFT) milliseconds. It counts that delay out on
// clk and then raises a one-cycle done pulse.
//
// Parameters:
//   CLKS_PER_MS  clock cycles per millisecond (>= 1)
//   MIN_MS       fixed minimum delay in ms (>= 1)
//   SCALE_SHIFT  left shift applied to rnd; MIN_MS + (255 << SCALE_SHIFT) <= 65535
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request a new random delay (ignored unless idle)
//   abort     in   cancel the delay in progress; wins over start
//   rnd       in   current LFSR state, sampled only on the accepting edge
//   step_en   out  LFSR advance enable (high while idle, including reset)
//   busy      out  delay in progress
//   done      out  one-cycle pulse when the delay expires
//   delay_ms  out  delay latched for the current/last run
//   ms_left   out  whole milliseconds remaining
module rand_delay_timer #(
    parameter int unsigned CLKS_PER_MS = 50000,
    parameter int unsigned MIN_MS      = 1000,
    parameter int unsigned SCALE_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  rnd,
    output logic        step_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] delay_ms,
    output logic [15:0] ms_left
);

    // At least one bit so CLKS_PER_MS = 1 still yields a legal counter.
    localparam int unsigned TICK_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLKS_PER_MS - 1);
    localparam logic [15:0]       MIN_MS_16 = 16'(MIN_MS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TICK_W-1:0] tick;
    logic [15:0]       new_delay;
    logic              accept;
    logic              tick_wrap;
    logic              last_ms;

    assign new_delay = MIN_MS_16 + ({8'b0, rnd} << SCALE_SHIFT);
    assign accept    = (state == IDLE) && start && !abort;
    assign tick_wrap = (tick == TICK_MAX);
    assign last_ms   = (ms_left == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode purely from the state register, so no input reaches an
    // output combinationally.
    always_comb begin
        state_next = state;
        step_en    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                step_en = 1'b1;
                busy    = 1'b0;
                if (start && !abort) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (tick_wrap && last_ms) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_ms <= '0;
            ms_left  <= '0;
            tick     <= '0;
        end else if (accept) begin
            delay_ms <= new_delay;
            ms_left  <= new_delay;
            tick     <= '0;
        end else if (state != IDLE && abort) begin
            ms_left <= '0;
            tick    <= '0;
        end else if (state == COUNT) begin
            if (tick_wrap) begin
                tick    <= '0;
                ms_left <= ms_left - 16'd1;
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rand_delay_timer.sv
// Self-checking bench for rand_delay_timer. Instance 0 uses the small
// basic-run parameters and instance 1 uses the default scaling with a short
// millisecond. A reference model tracks each run as "elapsed edges since
// acceptance" and derives every expected output arithmetically from that.
module tb_rand_delay_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st[2];
    logic        ab[2];
    logic [7:0]  rn[2];
    logic        step_en_o[2];
    logic        busy_o[2];
    logic        done_o[2];
    logic [15:0] dly_o[2];
    logic [15:0] msl_o[2];

    int unsigned p_c[2]   = '{4, 2};
    int unsigned p_min[2] = '{2, 1000};
    int unsigned p_sh[2]  = '{0, 2};

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned edges = 0;

    // Reference model state
    bit          m_run[2] = '{0, 0};
    int unsigned m_k[2]   = '{0, 0};
    int unsigned m_d[2]   = '{0, 0};

    always #5 clk = ~clk;

    rand_delay_timer #(
        .CLKS_PER_MS (4),
        .MIN_MS      (2),
        .SCALE_SHIFT (0)
    ) u_dut_basic (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (st[0]),
        .abort    (ab[0]),
        .rnd      (rn[0]),
        .step_en  (step_en_o[0]),
        .busy     (busy_o[0]),
        .done     (done_o[0]),
        .delay_ms (dly_o[0]),
        .ms_left  (msl_o[0])
    );

    rand_delay_timer #(
        .CLKS_PER_MS (2)
    ) u_dut_scale (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (st[1]),
        .abort    (ab[1]),
        .rnd      (rn[1]),
        .step_en  (step_en_o[1]),
        .busy     (busy_o[1]),
        .done     (done_o[1]),
        .delay_ms (dly_o[1]),
        .ms_left  (msl_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) edges++;

    // A run lasts D*C edges after acceptance; done shows when that many have
    // elapsed, and the following edge returns to idle.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_run[i] = 1'b0;
                m_k[i]   = 0;
                m_d[i]   = 0;
            end else if (!m_run[i]) begin
                if (st[i] && !ab[i]) begin
                    m_run[i] = 1'b1;
                    m_k[i]   = 0;
                    m_d[i]   = p_min[i] + int'(rn[i]) * (1 << p_sh[i]);
                end
            end else if (ab[i] || m_k[i] == m_d[i] * p_c[i]) begin
                m_run[i] = 1'b0;
                m_k[i]   = 0;
            end else begin
                m_k[i]++;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_run[i]));
            check($sformatf("step_en%0d", i), 32'(step_en_o[i]), 32'(!m_run[i]));
            check($sformatf("done%0d", i), 32'(done_o[i]),
                  32'(m_run[i] && m_k[i] == m_d[i] * p_c[i]));
            check($sformatf("delay_ms%0d", i), 32'(dly_o[i]), m_d[i]);
            check($sformatf("ms_left%0d", i), 32'(msl_o[i]),
                  m_run[i] ? m_d[i] - m_k[i] / p_c[i] : 0);
        end
    end

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_busy"},    32'(busy_o[i]),    0);
            check({tag, "_done"},    32'(done_o[i]),    0);
            check({tag, "_step_en"}, 32'(step_en_o[i]), 1);
            check({tag, "_dly"},     32'(dly_o[i]),     0);
            check({tag, "_msl"},     32'(msl_o[i]),     0);
        end
    endtask

    task automatic launch(input int idx, input logic [7:0] v, output int unsigned acc);
        @(negedge clk);
        st[idx] = 1'b1;
        rn[idx] = v;
        @(negedge clk);
        st[idx] = 1'b0;
        rn[idx] = 8'($urandom);
        acc = edges;
    endtask

    task automatic wait_done(input int idx, input int unsigned budget, input int unsigned acc,
                             input int unsigned exp_lat, input string tag);
        bit seen = 1'b0;
        for (int unsigned n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done_o[idx]) begin
                seen = 1'b1;
                check(tag, edges - acc, exp_lat);
            end
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_msl(input int idx, input logic [15:0] val, input int unsigned budget,
                            input string tag);
        bit seen = 1'b0;
        for (int unsigned n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (msl_o[idx] == val) seen = 1'b1;
        end
        check(tag, 32'(seen), 1);
    endtask

    task automatic no_done(input int idx, input int unsigned cycles, input string tag);
        int unsigned pulses = 0;
        for (int unsigned n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (done_o[idx]) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned acc;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0;
            ab[i] = 1'b0;
            rn[i] = 8'h00;
        end
        #1;
        check_reset_vals("por");
        #11 rst_n = 1'b1;

        // Basic run: D = 2 + 3 = 5 ms at 4 clocks per ms
        launch(0, 8'h03, acc);
        check("basic_dly", 32'(dly_o[0]), 5);
        wait_done(0, 40, acc, 20, "basic_lat");
        @(negedge clk);
        check("basic_busy_fall", 32'(busy_o[0]), 0);
        check("basic_done_fall", 32'(done_o[0]), 0);

        // Scaling: 1000 + 255*4 = 2020, then 1000
        launch(1, 8'hFF, acc);
        check("scale_ff_dly", 32'(dly_o[1]), 32'h07E4);
        wait_done(1, 4100, acc, 4040, "scale_ff_lat");
        @(negedge clk);
        launch(1, 8'h00, acc);
        check("scale_00_dly", 32'(dly_o[1]), 1000);
        wait_done(1, 2100, acc, 2000, "scale_00_lat");
        @(negedge clk);

        // Abort at ms_left = 3
        launch(0, 8'h03, acc);
        wait_msl(0, 16'd3, 40, "abort_reach3");
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        check("abort_busy", 32'(busy_o[0]), 0);
        check("abort_msl", 32'(msl_o[0]), 0);
        check("abort_step_en", 32'(step_en_o[0]), 1);
        no_done(0, 40, "abort_no_done");

        // Start during COUNT and during FIRE is ignored
        launch(0, 8'h03, acc);
        repeat (3) @(negedge clk);
        st[0] = 1'b1;
        rn[0] = 8'hAA;
        @(negedge clk);
        st[0] = 1'b0;
        check("coll_count_dly", 32'(dly_o[0]), 5);
        wait_done(0, 40, acc, 20, "coll_lat");
        st[0] = 1'b1;
        rn[0] = 8'h10;
        @(negedge clk);
        check("coll_fire_busy", 32'(busy_o[0]), 0);
        check("coll_fire_done", 32'(done_o[0]), 0);
        rn[0] = 8'h01;
        @(negedge clk);
        st[0] = 1'b0;
        check("coll_idle_acc", 32'(busy_o[0]), 1);
        check("coll_idle_dly", 32'(dly_o[0]), 3);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;

        // Start and abort together in idle
        st[0] = 1'b1;
        ab[0] = 1'b1;
        rn[0] = 8'h20;
        @(negedge clk);
        st[0] = 1'b0;
        ab[0] = 1'b0;
        check("sa_busy", 32'(busy_o[0]), 0);
        check("sa_dly", 32'(dly_o[0]), 3);

        // Asynchronous reset mid-run at ms_left = 2
        launch(0, 8'h03, acc);
        wait_msl(0, 16'd2, 40, "arst_reach2");
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        no_done(0, 40, "arst_no_done");

        // Randomized traffic on both instances
        for (int unsigned n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom_range(0, 7) == 0);
                ab[i] = ($urandom_range(0, 31) == 0);
                rn[i] = 8'($urandom);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0;
            ab[i] = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) ab[i] = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rand_delay_timer.md
# rand_delay_timer

Random-delay scheduler that sits directly downstream of the 8-bit LFSR in the reaction-time game datapath. While idle it keeps the LFSR stepping every clock, so the sampled value depends on when the player presses. On `start` it latches the current LFSR value and converts it to a millisecond delay. It then counts that delay out on the system clock and emits a single-cycle `done` pulse, which the game controller uses to light the stimulus LED.

## Interface
- `CLKS_PER_MS`, default 50000: clock cycles per millisecond; must be ≥ 1.
- `MIN_MS`, default 1000: fixed minimum delay in ms; must be ≥ 1.
- `SCALE_SHIFT`, default 2: random component is `rnd << SCALE_SHIFT` ms. Constraint: `MIN_MS + (255 << SCALE_SHIFT) ≤ 65535`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a new random delay; sampled on `clk` rising edge.
- `abort` in 1: cancel any delay in progress.
- `rnd` in 8: current LFSR state.
- `step_en` out 1: LFSR advance enable.
- `busy` out 1: delay in progress.
- `done` out 1: one-cycle pulse when the delay expires.
- `delay_ms` out 16: delay latched for the current/last run.
- `ms_left` out 16: whole milliseconds remaining.

## Operation
- FSM states are IDLE, COUNT and FIRE. Reset enters IDLE.
- Reset values: `busy`=0, `done`=0, `delay_ms`=0, `ms_left`=0, tick counter=0.
- `step_en` = (state==IDLE), decoded from state, so it is 1 during reset.
- `busy` = (state≠IDLE), decoded from state.
- `done` = (state==FIRE), decoded from state.
- IDLE:
  - On `start`=1 and `abort`=0, latch `delay_ms` ← `MIN_MS + ({8'b0,rnd} << SCALE_SHIFT)`, computed in 16 bits with no overflow given the constraint.
  - Same edge: `ms_left` ← same value, tick ← 0, go to COUNT.
  - Otherwise stay in IDLE with `delay_ms` and `ms_left` holding their values.
- COUNT:
  - Tick counts 0..`CLKS_PER_MS`-1 and wraps to 0.
  - On each wrap, `ms_left` decrements.
  - On the edge where tick = `CLKS_PER_MS`-1 and `ms_left` = 1: `ms_left` ← 0, go to FIRE.
- FIRE: unconditionally go to IDLE on the next edge.
- `abort`=1 in COUNT or FIRE: go to IDLE on the next edge; `ms_left` ← 0; tick ← 0; `done` is not asserted on that edge.
  - `abort` in FIRE cannot suppress the pulse already showing this cycle.
- `start` while in COUNT or FIRE is ignored; nothing is queued.
- `start` and `abort` together in IDLE: `abort` wins and the block stays in IDLE.
- `rnd` is sampled only on the accepting edge; later changes have no effect on the run.

## Timing
- Let start be accepted at edge N, and D = `delay_ms`.
- `busy` = 1 from edge N onward (visible in the cycle after N).
- `step_en` falls at the same edge N, so the LFSR stops advancing during the run.
- `done` is high for exactly one cycle, starting at edge N + D·`CLKS_PER_MS` and ending one edge later.
- `busy` and `done` fall together, and `step_en` returns to 1 at that same edge.
- Earliest next acceptance: `start` sampled at the edge that leaves FIRE is ignored. The first acceptable edge is the following one, since the block must be in IDLE.
- Asynchronous reset mid-run: immediately go to IDLE with all reset values; no `done`.
- No combinational path from any input to any output.

## Test plan
- Reset: assert `rst_n`=0 mid-simulation.
  - Required: `busy`=0, `done`=0, `delay_ms`=0, `ms_left`=0, `step_en`=1 immediately, without waiting for a clock edge.
- Basic run (`CLKS_PER_MS`=4, `MIN_MS`=2, `SCALE_SHIFT`=0): `rnd`=8'h03, 1-cycle `start`.
  - Required: `delay_ms`=5.
  - `ms_left` steps 5,4,3,2,1,0, one step every 4 cycles.
  - `done` is high in exactly one cycle, starting 20 edges after the accepting edge.
  - `busy` falls together with `done`.
- Scaling (defaults, `CLKS_PER_MS` overridden to 2): `rnd`=8'hFF.
  - Required: `delay_ms`=2020 (16'h07E4).
  - `rnd`=8'h00 gives `delay_ms`=1000.
  - `done` arrives 4040 and 2000 edges after the accepting edge, respectively.
- Abort: using the basic-run setup, pulse `abort` while `ms_left`=3.
  - Required: IDLE on the next edge, `ms_left`=0, `busy`=0, `step_en`=1.
  - No `done` pulse within the following 40 cycles.
- Collisions:
  - `start` pulses during COUNT and during FIRE: no restart, `delay_ms` unchanged, a single `done`.
  - `start`+`abort` together in IDLE: stays IDLE with `busy`=0.
  - `start` at the first IDLE cycle after FIRE: accepted.
- Async reset while `ms_left`=2: outputs reach reset values with no clock edge, and no `done` follows.
